// File: rtl/led_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package   : led_ctrl_pkg
// Purpose   : Shared constants for the LED blink controller: mode/state
//             encodings, period register width and burst length.
// Revision  : 1.0  initial release
// ============================================================================
package led_ctrl_pkg;

  // Mode encodings double as the FSM state encoding seen on the mode output.
  localparam logic [1:0] MODE_OFF   = 2'd0;
  localparam logic [1:0] MODE_BLINK = 2'd1;
  localparam logic [1:0] MODE_CHASE = 2'd2;
  localparam logic [1:0] MODE_BURST = 2'd3;

  localparam int PERIOD_W     = 10;
  // A burst is 3 on-phases plus 3 off-phases, i.e. 6 half-period events.
  localparam int BURST_EVENTS = 6;
  localparam int BURST_CNT_W  = 3;

endpackage : led_ctrl_pkg
`default_nettype wire

// File: rtl/tick_gen.sv
`default_nettype none
// ============================================================================
// Module    : tick_gen
// Purpose   : Clearable time-base divider. Counts 0..TICK_DIV-1 and asserts
//             tick for one cycle while the count sits at TICK_DIV-1.
// Ports     : clk  - system clock
//             rst  - asynchronous active-high reset
//             clr  - synchronous clear, forces the count back to 0
//             tick - one-cycle time-base pulse
// Revision  : 1.0  initial release
// ============================================================================
module tick_gen #(
  parameter int CLK_HZ  = 125_000_000,
  parameter int TICK_HZ = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int CNT_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  generate
    if ((CLK_HZ % TICK_HZ) != 0 || TICK_DIV < 2) begin : g_param_check
      $error("tick_gen: CLK_HZ/TICK_HZ must be an integer >= 2");
    end
  endgenerate

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Decoded straight from the counter flop; the controller consumes it
  // internally and only its registered results reach the pins.
  assign tick = (cnt == CNT_LAST);

endmodule : tick_gen
`default_nettype wire

// File: rtl/led_blink_ctrl.sv
`default_nettype none
// ============================================================================
// Module    : led_blink_ctrl
// Purpose   : Drives the board LEDs through OFF / BLINK / CHASE / BURST
//             patterns. Commands (mode + half-period) arrive on a valid/ready
//             handshake; pattern steps occur every half-period of ticks.
// Ports     : clk, rst    - clock, asynchronous active-high reset
//             cfg_valid   - command valid
//             cfg_ready   - command can be accepted (low during a burst)
//             cfg_mode    - requested mode (see led_ctrl_pkg encodings)
//             cfg_period  - half-period in ticks, 0 behaves as 1
//             led         - registered LED drive
//             done        - one-cycle pulse when a burst finishes
//             mode        - current state encoding
// Revision  : 1.0  initial release
// ============================================================================
module led_blink_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int CLK_HZ   = 125_000_000,
  parameter int TICK_HZ  = 1000,
  parameter int NUM_LEDS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [1:0]          cfg_mode,
  input  logic [PERIOD_W-1:0] cfg_period,
  output logic [NUM_LEDS-1:0] led,
  output logic                done,
  output logic [1:0]          mode
);

  generate
    if (NUM_LEDS < 2) begin : g_leds_check
      $error("led_blink_ctrl: NUM_LEDS must be >= 2");
    end
  endgenerate

  localparam logic [BURST_CNT_W-1:0] BURST_LAST = BURST_CNT_W'(BURST_EVENTS - 1);

  logic [PERIOD_W-1:0]    period;
  logic [PERIOD_W-1:0]    period_eff;
  logic [PERIOD_W-1:0]    hp_cnt;
  logic [BURST_CNT_W-1:0] burst_cnt;
  logic                   tick;
  logic                   accept;
  logic                   hp_event;

  // Ready is a pure decode of the state register: a burst runs to completion.
  assign cfg_ready  = (mode != MODE_BURST);
  assign accept     = cfg_valid && cfg_ready;
  assign period_eff = (period == '0) ? PERIOD_W'(1) : period;
  assign hp_event   = tick && (hp_cnt == period_eff - PERIOD_W'(1));

  // Accepting a command restarts the time base so the first pattern step
  // lands exactly period_eff*TICK_DIV cycles after the accepting edge.
  tick_gen #(
    .CLK_HZ  (CLK_HZ),
    .TICK_HZ (TICK_HZ)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode      <= MODE_OFF;
      period    <= PERIOD_W'(1);
      hp_cnt    <= '0;
      burst_cnt <= '0;
      led       <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        // A command on the same edge as a half-period event wins outright.
        mode      <= cfg_mode;
        period    <= cfg_period;
        hp_cnt    <= '0;
        burst_cnt <= '0;
        case (cfg_mode)
          MODE_BLINK: led <= '1;
          MODE_CHASE: led <= NUM_LEDS'(1);
          MODE_BURST: led <= '1;
          default:    led <= '0;
        endcase
      end else begin
        if (tick) begin
          hp_cnt <= hp_event ? '0 : hp_cnt + PERIOD_W'(1);
        end
        if (hp_event) begin
          case (mode)
            MODE_BLINK: led <= ~led;
            MODE_CHASE: led <= {led[NUM_LEDS-2:0], led[NUM_LEDS-1]};
            MODE_BURST: begin
              if (burst_cnt == BURST_LAST) begin
                mode      <= MODE_OFF;
                led       <= '0;
                done      <= 1'b1;
                burst_cnt <= '0;
              end else begin
                led       <= ~led;
                burst_cnt <= burst_cnt + BURST_CNT_W'(1);
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule : led_blink_ctrl
`default_nettype wire

// File: tb/tb_led_blink_ctrl.sv
`default_nettype none
// ============================================================================
// Module    : tb_led_blink_ctrl
// Purpose   : Scoreboard bench for led_blink_ctrl (CLK_HZ=1000, TICK_HZ=100,
//             so one tick every 10 cycles). Stimulus pushes expected
//             snapshots tagged with the edge number they belong to; the
//             monitor compares them and flags any LED change or done pulse
//             that nobody predicted.
// Revision  : 1.0  initial release
// ============================================================================
module tb_led_blink_ctrl;

  localparam int NUM_LEDS = 4;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                cfg_valid = 1'b0;
  logic                cfg_ready;
  logic [1:0]          cfg_mode = 2'd0;
  logic [9:0]          cfg_period = 10'd0;
  logic [NUM_LEDS-1:0] led;
  logic                done;
  logic [1:0]          mode;

  led_blink_ctrl #(
    .CLK_HZ   (1000),
    .TICK_HZ  (100),
    .NUM_LEDS (NUM_LEDS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_mode   (cfg_mode),
    .cfg_period (cfg_period),
    .led        (led),
    .done       (done),
    .mode       (mode)
  );

  always #5 clk = ~clk;

  // Edge counter: after rising edge k, cyc == k.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [3:0] led;
    logic [1:0] mode;
    logic       ready;
    logic       done;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic [3:0] prev_led = 4'b0000;

  task automatic push(input int c, input logic [3:0] l, input logic [1:0] m,
                      input logic r, input logic d, input string n);
    exp_t e;
    e.cyc = c; e.led = l; e.mode = m; e.ready = r; e.done = d; e.name = n;
    exp_q.push_back(e);
  endtask

  // Monitor: compares snapshots due on this edge, otherwise any output
  // activity is unexpected.
  always @(negedge clk) begin
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: snapshot for edge %0d never compared (now %0d)", e.name, e.cyc, cyc);
    end
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      e = exp_q.pop_front();
      checks++;
      if (led !== e.led || mode !== e.mode || cfg_ready !== e.ready || done !== e.done) begin
        errors++;
        $display("FAIL %s @%0d: got led=%b mode=%0d ready=%b done=%b, expected led=%b mode=%0d ready=%b done=%b",
                 e.name, cyc, led, mode, cfg_ready, done, e.led, e.mode, e.ready, e.done);
      end
    end else if (led !== prev_led || done !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_activity @%0d: got led=%b (was %b) done=%b, expected no change and done=0",
               cyc, led, prev_led, done);
    end
    prev_led = led;
  end

  // Present a command so that it is accepted on rising edge k.
  task automatic cmd_at(input int k, input logic [1:0] m, input logic [9:0] p);
    if (cyc > k - 1) begin
      checks++;
      errors++;
      $display("FAIL schedule: command for edge %0d issued at %0d, expected earlier", k, cyc);
    end
    while (cyc < k - 1) @(negedge clk);
    cfg_mode   = m;
    cfg_period = p;
    cfg_valid  = 1'b1;
    @(posedge clk);
    #1 cfg_valid = 1'b0;
  endtask

  task automatic wait_edge(input int k);
    while (cyc < k) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: simulation did not complete, got cycle %0d, expected 760", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    // Power-on reset, released mid-cycle.
    push(5, 4'b0000, 2'd0, 1'b1, 1'b0, "reset_state");
    wait_edge(3);
    @(negedge clk);
    rst = 1'b0;

    // BLINK period 3 at edge 10: toggles every 30 cycles.
    push(10,  4'b1111, 2'd1, 1'b1, 1'b0, "blink3_init");
    push(40,  4'b0000, 2'd1, 1'b1, 1'b0, "blink3_ev1");
    push(70,  4'b1111, 2'd1, 1'b1, 1'b0, "blink3_ev2");
    push(100, 4'b0000, 2'd1, 1'b1, 1'b0, "blink3_ev3");
    cmd_at(10, 2'd1, 10'd3);

    // BLINK period 0 behaves as period 1: toggles every 10 cycles.
    push(105, 4'b1111, 2'd1, 1'b1, 1'b0, "blink0_init");
    push(115, 4'b0000, 2'd1, 1'b1, 1'b0, "blink0_ev1");
    push(125, 4'b1111, 2'd1, 1'b1, 1'b0, "blink0_ev2");
    push(135, 4'b0000, 2'd1, 1'b1, 1'b0, "blink0_ev3");
    cmd_at(105, 2'd1, 10'd0);

    // CHASE period 1 with wrap, then OFF.
    push(140, 4'b0001, 2'd2, 1'b1, 1'b0, "chase_init");
    push(150, 4'b0010, 2'd2, 1'b1, 1'b0, "chase_ev1");
    push(160, 4'b0100, 2'd2, 1'b1, 1'b0, "chase_ev2");
    push(170, 4'b1000, 2'd2, 1'b1, 1'b0, "chase_ev3");
    push(180, 4'b0001, 2'd2, 1'b1, 1'b0, "chase_wrap");
    cmd_at(140, 2'd2, 10'd1);
    push(185, 4'b0000, 2'd0, 1'b1, 1'b0, "off_cmd");
    cmd_at(185, 2'd0, 10'd1);

    // BURST period 2 at edge 200 with a BLINK command held pending.
    push(200, 4'b1111, 2'd3, 1'b0, 1'b0, "burst_init");
    push(220, 4'b0000, 2'd3, 1'b0, 1'b0, "burst_ph2");
    push(240, 4'b1111, 2'd3, 1'b0, 1'b0, "burst_ph3");
    push(260, 4'b0000, 2'd3, 1'b0, 1'b0, "burst_ph4");
    push(280, 4'b1111, 2'd3, 1'b0, 1'b0, "burst_ph5");
    push(300, 4'b0000, 2'd3, 1'b0, 1'b0, "burst_ph6");
    push(310, 4'b0000, 2'd3, 1'b0, 1'b0, "burst_blocks_cmd");
    push(320, 4'b0000, 2'd0, 1'b1, 1'b1, "burst_done");
    push(321, 4'b1111, 2'd1, 1'b1, 1'b0, "held_cmd_accept");
    cmd_at(200, 2'd3, 10'd2);
    cfg_mode   = 2'd1;
    cfg_period = 10'd1;
    cfg_valid  = 1'b1;
    wait_edge(321);
    cfg_valid  = 1'b0;

    // BLINK period 1 runs, then BLINK period 5, then CHASE on an event edge.
    push(331, 4'b0000, 2'd1, 1'b1, 1'b0, "blink1_ev1");
    push(341, 4'b1111, 2'd1, 1'b1, 1'b0, "blink1_ev2");
    push(346, 4'b1111, 2'd1, 1'b1, 1'b0, "blink5_init");
    push(396, 4'b0000, 2'd1, 1'b1, 1'b0, "blink5_ev1");
    cmd_at(346, 2'd1, 10'd5);
    push(446, 4'b0001, 2'd2, 1'b1, 1'b0, "chase_wins_event");
    push(496, 4'b0010, 2'd2, 1'b1, 1'b0, "chase_after_50");
    cmd_at(446, 2'd2, 10'd5);

    // BURST interrupted by reset at k+35.
    push(510, 4'b1111, 2'd3, 1'b0, 1'b0, "burst2_init");
    push(530, 4'b0000, 2'd3, 1'b0, 1'b0, "burst2_ph2");
    push(545, 4'b0000, 2'd0, 1'b1, 1'b0, "reset_mid_burst");
    push(750, 4'b0000, 2'd0, 1'b1, 1'b0, "idle_after_reset");
    cmd_at(510, 2'd3, 10'd2);
    wait_edge(545);
    rst = 1'b1;
    wait_edge(548);
    rst = 1'b0;

    wait_edge(760);
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: snapshot for edge %0d never compared", e.name, e.cyc);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_led_blink_ctrl
`default_nettype wire
